// File: rtl/i2c_req_arbiter.sv
// Two-client round-robin front end for the i2c_ctrl EEPROM master (sys_clk domain).
// Optional post-write tWR idle state is enabled with `define I2C_WR_WAIT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; grants and acks in the same cycle
// START  | i2c_start held for START_HOLD cycles, timeout counter running
// BUSY   | waiting for the i2c_end rising edge or timeout
// WRWAIT | post-write EEPROM tWR idle (only with I2C_WR_WAIT_EN)
`timescale 1ns/1ps
module i2c_req_arbiter #(
  parameter int   START_HOLD = 50,
  parameter int   TIMEOUT    = 200000,
  parameter int   WR_WAIT    = 250000,
  parameter logic ADDR_NUM   = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_a,
  input  logic        wr_a,
  input  logic [15:0] addr_a,
  input  logic [7:0]  wdata_a,
  output logic        ack_a,
  output logic        done_a,
  input  logic        req_b,
  input  logic        wr_b,
  input  logic [15:0] addr_b,
  input  logic [7:0]  wdata_b,
  output logic        ack_b,
  output logic        done_b,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy,
  output logic        wr_en,
  output logic        rd_en,
  output logic        i2c_start,
  output logic        addr_num,
  output logic [15:0] byte_addr,
  output logic [7:0]  i2c_write_data,
  input  logic        i2c_end,
  input  logic [7:0]  i2c_read_data
);

  localparam int CNT_MAX =
    (TIMEOUT > WR_WAIT) ? ((TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD)
                        : ((WR_WAIT > START_HOLD) ? WR_WAIT : START_HOLD);
  localparam int CW = $clog2(CNT_MAX + 1);

`ifdef I2C_WR_WAIT_EN
  typedef enum logic [1:0] {IDLE, START, BUSY, WRWAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_b_q;
  logic          gnt_b_q;
  logic          wr_q;
  logic          i2c_end_q;
  logic [7:0]    rdata_q;
  logic          err_q;

  logic end_rise, idle, in_xfer;
  logic grant_a, grant_b, take_a, take_b, take;
  logic fin_ok, fin_to, fin;
  logic hold_done;

  assign end_rise = i2c_end & ~i2c_end_q;
  assign idle     = (state_q == IDLE);
  assign in_xfer  = (state_q == START) || (state_q == BUSY);

  // Tie goes to the client that was not granted last
  assign grant_a = req_a & (~req_b | last_b_q);
  assign grant_b = req_b & (~req_a | ~last_b_q);
  assign take_a  = idle & grant_a & sys_rst_n;
  assign take_b  = idle & grant_b & sys_rst_n;
  assign take    = take_a | take_b;

  assign fin_ok    = in_xfer & end_rise;
  assign fin_to    = in_xfer & ~end_rise & (cnt_q == CW'(TIMEOUT - 1));
  assign fin       = fin_ok | fin_to;
  assign hold_done = (state_q == START) && (cnt_q == CW'(START_HOLD - 1));

  assign ack_a    = take_a;
  assign ack_b    = take_b;
  assign done_a   = fin & ~gnt_b_q;
  assign done_b   = fin & gnt_b_q;
  // Status is valid in the done cycle itself, then held from the registers
  assign err      = fin ? fin_to : err_q;
  assign rdata    = (fin_ok & ~wr_q) ? i2c_read_data : rdata_q;
  assign busy     = ~idle;
  assign addr_num = ADDR_NUM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (take) state_d = START;
      end
      START, BUSY: begin
        if (fin) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef I2C_WR_WAIT_EN
          if (fin_ok && wr_q) state_d = WRWAIT;
`endif
        end else if (hold_done) begin
          // timeout counter keeps running across START -> BUSY
          state_d = BUSY;
        end
      end
`ifdef I2C_WR_WAIT_EN
      WRWAIT: begin
        if (cnt_q == CW'(WR_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_b_q       <= 1'b1;
      gnt_b_q        <= 1'b0;
      wr_q           <= 1'b0;
      i2c_end_q      <= 1'b0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      wr_en          <= 1'b0;
      rd_en          <= 1'b0;
      i2c_start      <= 1'b0;
      byte_addr      <= '0;
      i2c_write_data <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      i2c_end_q <= i2c_end;
      if (take) begin
        gnt_b_q        <= take_b;
        last_b_q       <= take_b;
        wr_q           <= take_b ? wr_b : wr_a;
        wr_en          <= take_b ? wr_b : wr_a;
        rd_en          <= take_b ? ~wr_b : ~wr_a;
        byte_addr      <= take_b ? addr_b : addr_a;
        i2c_write_data <= take_b ? wdata_b : wdata_a;
        i2c_start      <= 1'b1;
      end else if (fin) begin
        wr_en     <= 1'b0;
        rd_en     <= 1'b0;
        i2c_start <= 1'b0;
        err_q     <= fin_to;
        if (fin_ok && !wr_q) rdata_q <= i2c_read_data;
      end else if (hold_done) begin
        i2c_start <= 1'b0;
      end
    end
  end

endmodule
